// File: rtl/dosing_pkg.sv
// Shared types and constants for the dosing timer.
// Channel indices, FSM state encoding and one-hot motor codes.
package dosing_pkg;

  localparam int CH_R = 2;
  localparam int CH_Y = 1;
  localparam int CH_B = 0;

  localparam logic [2:0] M_R = 3'b100;
  localparam logic [2:0] M_Y = 3'b010;
  localparam logic [2:0] M_B = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [2:0] m);
    return (m == M_R) || (m == M_Y) || (m == M_B);
  endfunction

endpackage

// File: rtl/dosing_timer_prescaler.sv
// Unit prescaler: counts 0..TICKS-1 while enabled.
// unit_tick marks the enabled cycle that wraps the count.
module unit_prescaler #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic unit_tick
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then advance/wrap when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign unit_tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/dosing_timer.sv
// Per-channel dosing timer: times the active motor for amount x TICKS_PER_UNIT.
// Optional DOSING_PAUSE_EN adds a pausa input that freezes timing in RUN.
module dosing_timer
  import dosing_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 5_000_000,
  parameter int AMOUNT_W       = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [AMOUNT_W-1:0] amount_r,
  input  logic [AMOUNT_W-1:0] amount_y,
  input  logic [AMOUNT_W-1:0] amount_b,
  input  logic [2:0]          motores,
`ifdef DOSING_PAUSE_EN
  input  logic                pausa,
`endif
  output logic [2:0]          flags,
  output logic                busy,
  output logic [AMOUNT_W-1:0] remaining
);

  localparam logic [AMOUNT_W-1:0] ONE = AMOUNT_W'(1);

  state_e                       state_q, state_d;
  logic [2:0]                   chan_q, chan_d;
  logic [2:0]                   flags_q, flags_d;
  logic [AMOUNT_W-1:0]          rem_q, rem_d;
  logic [2:0][AMOUNT_W-1:0]     amt_q, amt_d;
  logic                         hold;
  logic                         pre_en;
  logic                         pre_clr;
  logic                         tick;

`ifdef DOSING_PAUSE_EN
  assign hold = pausa;
`else
  assign hold = 1'b0;
`endif

  assign pre_clr = (state_q != ST_RUN);
  assign pre_en  = (state_q == ST_RUN) && (motores == chan_q)
                && (rem_q != '0) && !hold;

  unit_prescaler #(
    .TICKS (TICKS_PER_UNIT)
  ) u_pre (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (pre_clr),
    .en        (pre_en),
    .unit_tick (tick)
  );

  // Amount latch: only accepted outside RUN
  always_comb begin
    amt_d = amt_q;
    if (load && state_q != ST_RUN) begin
      amt_d[CH_R] = amount_r;
      amt_d[CH_Y] = amount_y;
      amt_d[CH_B] = amount_b;
    end
  end

  // FSM next state, channel capture, countdown and done pulse
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    rem_d   = rem_q;
    flags_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (is_onehot(motores)) begin
          state_d = ST_RUN;
          chan_d  = motores;
          unique case (1'b1)
            motores[CH_R]: rem_d = amt_q[CH_R];
            motores[CH_Y]: rem_d = amt_q[CH_Y];
            motores[CH_B]: rem_d = amt_q[CH_B];
            default:       rem_d = '0;
          endcase
        end
      end
      ST_RUN: begin
        if (motores != chan_q) begin
          state_d = ST_IDLE;
        end else if (rem_q == '0) begin
          flags_d = chan_q;
          state_d = ST_DONE;
        end else if (tick) begin
          rem_d = rem_q - ONE;
        end
      end
      ST_DONE: begin
        if (motores != chan_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      flags_q <= '0;
      rem_q   <= '0;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      flags_q <= flags_d;
      rem_q   <= rem_d;
      amt_q   <= amt_d;
    end
  end

  assign flags     = flags_q;
  assign busy      = (state_q == ST_RUN);
  assign remaining = busy ? rem_q : '0;

endmodule

// File: tb/tb_dosing_timer.sv
// Directed vector bench for dosing_timer (TICKS_PER_UNIT=4).
// Pause latency sequence runs only with DOSING_PAUSE_EN.
module tb_dosing_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [4:0] amount_r = '0;
  logic [4:0] amount_y = '0;
  logic [4:0] amount_b = '0;
  logic [2:0] motores = '0;
  logic       pausa = 1'b0;
  logic [2:0] flags;
  logic       busy;
  logic [4:0] remaining;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dosing_timer #(
    .TICKS_PER_UNIT (4),
    .AMOUNT_W       (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .amount_r  (amount_r),
    .amount_y  (amount_y),
    .amount_b  (amount_b),
    .motores   (motores),
`ifdef DOSING_PAUSE_EN
    .pausa     (pausa),
`endif
    .flags     (flags),
    .busy      (busy),
    .remaining (remaining)
  );

  typedef struct {
    logic       ld;
    logic [4:0] r, y, b;
    logic [2:0] mot;
    logic [2:0] fl;
    logic       bz;
    logic [4:0] rm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic ld, int r, int y, int b,
                              logic [2:0] mot, logic [2:0] fl,
                              logic bz, int rm);
    vec_t v;
    v.ld = ld; v.r = 5'(r); v.y = 5'(y); v.b = 5'(b);
    v.mot = mot; v.fl = fl; v.bz = bz; v.rm = 5'(rm);
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(string tag, logic [2:0] fl, logic bz, int rm);
    check({tag, ".flags"}, int'(flags), int'(fl));
    check({tag, ".busy"}, int'(busy), int'(bz));
    check({tag, ".remaining"}, int'(remaining), rm);
  endtask

  task automatic step(logic ld, int r, int y, int b, logic [2:0] mot);
    @(negedge clk);
    load = ld; amount_r = 5'(r); amount_y = 5'(y); amount_b = 5'(b);
    motores = mot;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // R=3,Y=0,B=2 loaded; red held until done
    add(1,3,0,2,3'b000, 3'b000,0,0);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,0);
    add(0,0,0,0,3'b100, 3'b100,0,0);
    add(0,0,0,0,3'b100, 3'b000,0,0);
    add(0,0,0,0,3'b100, 3'b000,0,0);
    // yellow, amount 0
    add(0,0,0,0,3'b010, 3'b000,0,0);
    add(0,0,0,0,3'b010, 3'b000,1,0);
    add(0,0,0,0,3'b010, 3'b010,0,0);
    add(0,0,0,0,3'b010, 3'b000,0,0);
    // blue, amount 2
    add(0,0,0,0,3'b001, 3'b000,0,0);
    add(0,0,0,0,3'b001, 3'b000,1,2);
    add(0,0,0,0,3'b001, 3'b000,1,2);
    add(0,0,0,0,3'b001, 3'b000,1,2);
    add(0,0,0,0,3'b001, 3'b000,1,2);
    add(0,0,0,0,3'b001, 3'b000,1,1);
    add(0,0,0,0,3'b001, 3'b000,1,1);
    add(0,0,0,0,3'b001, 3'b000,1,1);
    add(0,0,0,0,3'b001, 3'b000,1,1);
    add(0,0,0,0,3'b001, 3'b000,1,0);
    add(0,0,0,0,3'b001, 3'b001,0,0);
    add(0,0,0,0,3'b001, 3'b000,0,0);
    // abort after 6 cycles of red
    add(0,0,0,0,3'b000, 3'b000,0,0);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b000, 3'b000,0,0);
    add(0,0,0,0,3'b000, 3'b000,0,0);
    // multi-hot stays idle
    add(0,0,0,0,3'b110, 3'b000,0,0);
    add(0,0,0,0,3'b110, 3'b000,0,0);
    add(0,0,0,0,3'b011, 3'b000,0,0);
    // load strobed mid-RUN does not disturb the count
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(1,1,5,5,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,3);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b100, 3'b000,1,2);
    add(0,0,0,0,3'b000, 3'b000,0,0);
    // new amounts loaded in IDLE, used on next entry
    add(1,1,5,5,3'b000, 3'b000,0,0);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,1);
    add(0,0,0,0,3'b100, 3'b000,1,0);
    add(0,0,0,0,3'b100, 3'b100,0,0);
    add(0,0,0,0,3'b100, 3'b000,0,0);
    add(0,0,0,0,3'b000, 3'b000,0,0);

    // reset state
    #2;
    check_out("reset", 3'b000, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].r, vecs[i].y, vecs[i].b, vecs[i].mot);
      check_out($sformatf("row%0d", i), vecs[i].fl, vecs[i].bz,
                int'(vecs[i].rm));
    end

    // reset pulsed mid-RUN with remaining=2
    step(1, 2, 5, 5, 3'b000);
    step(0, 0, 0, 0, 3'b100);
    check_out("rst_pre0", 3'b000, 1'b1, 2);
    step(0, 0, 0, 0, 3'b100);
    check_out("rst_pre1", 3'b000, 1'b1, 2);
    @(negedge clk);
    reset = 1'b0;
    motores = 3'b000;
    #1;
    check_out("rst_mid", 3'b000, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (flags != 3'b000) seen++;
      end
      check("rst_no_pulse", seen, 0);
    end
    // latched amounts were cleared: red finishes on first edge
    step(0, 0, 0, 0, 3'b100);
    check_out("rst_amt0", 3'b000, 1'b1, 0);
    step(0, 0, 0, 0, 3'b100);
    check_out("rst_amt1", 3'b100, 1'b0, 0);
    step(0, 0, 0, 0, 3'b000);

`ifdef DOSING_PAUSE_EN
    // R=2 with 5 paused cycles: flag at edge 9+5=14
    step(1, 2, 0, 0, 3'b000);
    step(0, 0, 0, 0, 3'b100);
    begin
      int hit;
      hit = 0;
      for (int k = 1; k <= 30 && hit == 0; k++) begin
        @(negedge clk);
        pausa = (k >= 2 && k <= 6);
        @(posedge clk);
        #1;
        if (flags == 3'b100) hit = k;
      end
      pausa = 1'b0;
      check("pause_latency", hit, 14);
    end
    step(0, 0, 0, 0, 3'b000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
